// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, inverse twiddles, bit-reverse and FSM states for the Q=65537 NTT blocks
package ntt_pkg;

    localparam int unsigned Q    = 65537;
    localparam int unsigned LOGD = 4;

    localparam logic [17:0] Q_EXT = 18'd65537;
    localparam logic [16:0] W_INV = 17'd49153;
    localparam logic [16:0] D_INV = 17'd61441;

    // w^-k mod Q for k = 0..7, with w = 4 (so w^-k = Q - 4^(8-k) for k >= 1)
    localparam logic [16:0] TW_INV [8] = '{
        17'd1,     17'd49153, 17'd61441, 17'd64513,
        17'd65281, 17'd65473, 17'd65521, 17'd65533
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BFLY  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] bitrev(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

endpackage

// File: rtl/modmul_q.sv
// rtl/modmul_q.sv - combinational 17x17 multiply reduced mod 65537
// Ports: x_i, y_i - operands; p_o - (x_i * y_i) mod 65537, fully reduced.
module modmul_q
    import ntt_pkg::*;
(
    input  logic [16:0] x_i,
    input  logic [16:0] y_i,
    output logic [16:0] p_o
);

    logic [33:0] prod;
    logic [17:0] r0;
    logic [17:0] r1;

    assign prod = {17'd0, x_i} * {17'd0, y_i};

    // 2^16 == -1 and 2^32 == 1 mod Q: fold as lo - mid + top, biased by +Q to stay non-negative.
    // r0 lies in [2, 131075], so two conditional subtractions always land in [0, Q-1].
    assign r0  = {2'd0, prod[15:0]} + {16'd0, prod[33:32]} + Q_EXT - {2'd0, prod[31:16]};
    assign r1  = (r0 >= Q_EXT) ? (r0 - Q_EXT) : r0;
    assign p_o = (r1 >= Q_EXT) ? 17'(r1 - Q_EXT) : r1[16:0];

endmodule

// File: rtl/intt_seq.sv
// rtl/intt_seq.sv - sequential 16-point inverse NTT mod 65537, one butterfly per cycle
// Ports: clk, rst_n (async active-low); start - begin transform (ignored while busy);
//        a - NTT-domain input, coefficient i at a[N*i +: N]; busy - transform in progress;
//        done - one-cycle pulse when b is valid; b - natural-order result, same packing as a.
module intt_seq #(
    parameter int N = 17,
    parameter int D = 16,
    parameter int Q = 65537
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [D*N-1:0] a,
    output logic           busy,
    output logic           done,
    output logic [D*N-1:0] b
);

    localparam logic [N:0] QX = (N+1)'(Q);

    ntt_pkg::state_e       state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [D-1:0][N-1:0]   rf_q, rf_d;
    logic [D-1:0][N-1:0]   b_q, b_d;

    logic [1:0]   stage;
    logic [2:0]   bf;
    logic [3:0]   ix, iy;
    logic [2:0]   tw_e;
    logic [N-1:0] x, y, sum_m, diff_m;
    logic [N:0]   sum_raw, diff_raw;
    logic [N-1:0] mul_a, mul_b, mul_p;

    // In BFLY the counter is {stage, butterfly}; in SCALE it is the coefficient index.
    assign stage = cnt_q[4:3];
    assign bf    = cnt_q[2:0];

    // Pair addressing: spacing m = 8 >> stage, group g = bf / m, offset j = bf % m,
    // x at g*2m + j, y at x + m; twiddle exponent is j << stage.
    always_comb begin
        ix   = 4'd0;
        tw_e = 3'd0;
        case (stage)
            2'd0: begin ix = {1'b0, bf};               tw_e = bf;                end
            2'd1: begin ix = {bf[2], 1'b0, bf[1:0]};   tw_e = {bf[1:0], 1'b0};   end
            2'd2: begin ix = {bf[2:1], 1'b0, bf[0]};   tw_e = {bf[0], 2'b00};    end
            default: begin ix = {bf, 1'b0};            tw_e = 3'd0;              end
        endcase
    end

    assign iy = ix | (4'd8 >> stage);
    assign x  = rf_q[ix];
    assign y  = rf_q[iy];

    assign sum_raw  = {1'b0, x} + {1'b0, y};
    assign sum_m    = (sum_raw >= QX) ? N'(sum_raw - QX) : sum_raw[N-1:0];
    assign diff_raw = {1'b0, x} - {1'b0, y};
    assign diff_m   = (x >= y) ? N'(x - y) : N'(diff_raw + QX);

    // The single multiplier serves the butterfly twiddle and the final 1/D scaling.
    assign mul_a = (state_q == ntt_pkg::SCALE) ? rf_q[cnt_q[3:0]] : diff_m;
    assign mul_b = (state_q == ntt_pkg::SCALE) ? ntt_pkg::D_INV : ntt_pkg::TW_INV[tw_e];

    modmul_q u_modmul (
        .x_i (mul_a),
        .y_i (mul_b),
        .p_o (mul_p)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rf_d    = rf_q;
        b_d     = b_q;
        case (state_q)
            ntt_pkg::IDLE: begin
                if (start) begin
                    rf_d    = a;
                    cnt_d   = 5'd0;
                    state_d = ntt_pkg::BFLY;
                end
            end
            ntt_pkg::BFLY: begin
                rf_d[ix] = sum_m;
                rf_d[iy] = mul_p;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = ntt_pkg::SCALE;
                end
            end
            ntt_pkg::SCALE: begin
                // Indices 0..15 write one scaled coefficient each; index 16 is a
                // closing cycle with no write before the done pulse.
                if (!cnt_q[4]) begin
                    b_d[ntt_pkg::bitrev(cnt_q[3:0])] = mul_p;
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    cnt_d   = 5'd0;
                    state_d = ntt_pkg::DONE;
                end
            end
            ntt_pkg::DONE: begin
                state_d = ntt_pkg::IDLE;
            end
            default: begin
                state_d = ntt_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ntt_pkg::IDLE;
            cnt_q   <= '0;
            rf_q    <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rf_q    <= rf_d;
            b_q     <= b_d;
        end
    end

    assign busy = (state_q != ntt_pkg::IDLE);
    assign done = (state_q == ntt_pkg::DONE);
    assign b    = b_q;

endmodule

// File: tb/tb_intt_seq.sv
// tb/tb_intt_seq.sv - self-checking bench for intt_seq against a direct-sum NTT/INTT model
module tb_intt_seq;

    localparam int     N = 17;
    localparam int     D = 16;
    localparam longint Q = 65537;
    localparam int     LAT = 49;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [D*N-1:0] a     = '0;
    logic           busy;
    logic           done;
    logic [D*N-1:0] b;

    int checks = 0;
    int errors = 0;

    longint wpow  [D];
    longint wipow [D];

    intt_seq #(.N(N), .D(D), .Q(65537)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .b     (b)
    );

    always #5 clk = ~clk;

    function automatic longint powmod(input longint base, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * base) % Q;
        return r;
    endfunction

    // Forward transform with w = 4: A[k] = sum v[n] * w^(n*k) mod Q
    function automatic logic [D*N-1:0] ref_ntt(input logic [D*N-1:0] v);
        logic [D*N-1:0] r;
        longint acc, t;
        r = '0;
        for (int k = 0; k < D; k++) begin
            acc = 0;
            for (int n = 0; n < D; n++) begin
                t   = v[N*n +: N];
                acc = (acc + t * wpow[(n*k) % D]) % Q;
            end
            r[N*k +: N] = N'(acc);
        end
        return r;
    endfunction

    // Inverse transform: b[i] = D^-1 * sum a[j] * w^(-i*j) mod Q
    function automatic logic [D*N-1:0] ref_intt(input logic [D*N-1:0] av);
        logic [D*N-1:0] r;
        longint acc, t;
        r = '0;
        for (int i = 0; i < D; i++) begin
            acc = 0;
            for (int j = 0; j < D; j++) begin
                t   = av[N*j +: N];
                acc = (acc + t * wipow[(i*j) % D]) % Q;
            end
            r[N*i +: N] = N'((acc * 61441) % Q);
        end
        return r;
    endfunction

    function automatic logic [D*N-1:0] rand_vec();
        logic [D*N-1:0] r;
        for (int i = 0; i < D; i++) r[N*i +: N] = N'($urandom_range(0, 65536));
        return r;
    endfunction

    task automatic kick(input logic [D*N-1:0] av);
        @(negedge clk);
        a     = av;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < n0 + 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (b !== '0) begin errors++; $display("FAIL reset_b: got %h expected 0", b); end
        rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        logic [D*N-1:0] av, expv, hold;
        int n;
        for (int i = 0; i < D; i++) av[N*i +: N] = N'(1);
        expv = '0;
        expv[N-1:0] = N'(1);
        kick(av);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b expected 1", busy); end
        wait_done(0, n);
        checks++; if (done !== 1'b1 || n != LAT) begin errors++; $display("FAIL ones_latency: got done=%b after %0d edges expected done=1 after %0d", done, n, LAT); end
        checks++; if (b !== expv) begin errors++; $display("FAIL ones_result: got %h expected %h", b, expv); end
        hold = b;
        @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ones_after_done: got done=%b busy=%b expected 0 0", done, busy); end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++; if (b !== hold) begin errors++; $display("FAIL ones_hold: got %h expected %h", b, hold); end
    endtask

    task automatic test_delta();
        logic [D*N-1:0] av, expv;
        int n;
        av = '0;
        av[N-1:0] = N'(1);
        for (int i = 0; i < D; i++) expv[N*i +: N] = N'(61441);
        kick(av);
        wait_done(0, n);
        checks++; if (done !== 1'b1 || b !== expv) begin errors++; $display("FAIL delta_result: got done=%b b=%h expected done=1 b=%h", done, b, expv); end
    endtask

    task automatic test_roundtrip();
        logic [D*N-1:0] v;
        int n;
        for (int t = 0; t < 1000; t++) begin
            if (t == 0) v = '0;
            else if (t == 1) begin
                for (int i = 0; i < D; i++) v[N*i +: N] = N'(65536);
            end else v = rand_vec();
            kick(ref_ntt(v));
            wait_done(0, n);
            checks++;
            if (done !== 1'b1 || n != LAT || b !== v) begin
                errors++;
                $display("FAIL roundtrip_%0d: got done=%b edges=%0d b=%h expected %h", t, done, n, b, v);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [D*N-1:0] v1, v2, got;
        int n, ndone;
        v1 = rand_vec();
        v2 = rand_vec();
        got = '0;
        kick(ref_ntt(v1));
        n = 0;
        ndone = 0;
        while (n < 60) begin
            if (n == 9) begin
                start = 1'b1;
                a     = ref_ntt(v2);
            end else start = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                got = b;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (got !== v1) begin errors++; $display("FAIL ignore_result: got %h expected %h", got, v1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [D*N-1:0] v1, v2;
        int n;
        v1 = rand_vec();
        v2 = rand_vec();
        kick(ref_ntt(v1));
        repeat (20) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (b !== '0) begin errors++; $display("FAIL midreset_b: got %h expected 0", b); end
        @(negedge clk);
        rst_n = 1'b1;
        a     = ref_ntt(v2);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_accept: got busy=%b expected 1", busy); end
        wait_done(0, n);
        checks++; if (done !== 1'b1 || n != LAT || b !== v2) begin errors++; $display("FAIL midreset_result: got done=%b edges=%0d b=%h expected %h", done, n, b, v2); end
    endtask

    task automatic test_back_to_back();
        logic [D*N-1:0] va, vb, av;
        int n;
        va = rand_vec();
        vb = rand_vec();
        av = ref_intt(ref_ntt(va));
        checks++; if (av !== va) begin errors++; $display("FAIL model_roundtrip: got %h expected %h", av, va); end
        kick(ref_ntt(va));
        wait_done(0, n);
        checks++; if (done !== 1'b1 || busy !== 1'b1 || b !== va) begin errors++; $display("FAIL b2b_first: got done=%b busy=%b b=%h expected 1 1 %h", done, busy, b, va); end
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b expected 0", busy); end
        a     = ref_ntt(vb);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        repeat (32) begin @(posedge clk); @(negedge clk); end
        checks++; if (b !== va) begin errors++; $display("FAIL b2b_hold: got %h expected %h", b, va); end
        wait_done(32, n);
        checks++; if (done !== 1'b1 || n != LAT || b !== vb) begin errors++; $display("FAIL b2b_second: got done=%b edges=%0d b=%h expected %h", done, n, b, vb); end
    endtask

    initial begin
        for (int e = 0; e < D; e++) begin
            wpow[e]  = powmod(4, e);
            wipow[e] = powmod(49153, e);
        end
        test_reset();
        test_all_ones();
        test_delta();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
